// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX FIFO arbiter.
// State encoding, channel-index width helper and default stall timeout.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StCapt = 2'd2,
    StSend = 2'd3
  } arb_state_e;

  localparam int unsigned DefaultTimeout = 1024;

  // Width of a channel index; never below one bit.
  function automatic int unsigned ch_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first requester after ptr, wrapping
// modulo NUM_CH. Returns one-hot grant, encoded index and a found flag.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   idx,
  output logic              found
);

  function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] p, input int unsigned off);
    int unsigned s;
    s = (32'(p) + off) % NUM_CH;
    return CH_W'(s);
  endfunction

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    // Lowest offset from ptr wins; ptr itself is scanned last.
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      if (!found && req[wrap_idx(ptr, off)]) begin
        found                    = 1'b1;
        idx                      = wrap_idx(ptr, off);
        gnt[wrap_idx(ptr, off)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo_arbiter.sv
// Packet-atomic round-robin arbiter feeding one UART TX byte port from NUM_CH
// FIFOs with one-cycle read latency; a granted channel keeps the port per frame.
module uart_tx_fifo_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = DefaultTimeout,
  localparam int unsigned CH_W   = ch_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       fifo_empty,
  input  logic [NUM_CH-1:0]       fifo_wr_en,
  input  logic [NUM_CH*WIDTH-1:0] fifo_dout,
  input  logic [NUM_CH-1:0]       fifo_dout_last,
  output logic [NUM_CH-1:0]       fifo_rd_en,
  output logic [WIDTH-1:0]        tx_data,
  output logic                    tx_last,
  output logic [CH_W-1:0]         tx_chan,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    frame_abort
);

  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TimerLast = TMR_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [NUM_CH-1:0] grant_oh_q, grant_oh_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [WIDTH-1:0]  tx_data_q, tx_data_d;
  logic              tx_last_q, tx_last_d;
  logic [CH_W-1:0]   tx_chan_q, tx_chan_d;

  logic [NUM_CH-1:0] pick_gnt;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_found;
  logic              read_ok;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_pick (
    .req   (~fifo_empty),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // A same-cycle write wins over a read inside the FIFO, so hold off the read.
  assign read_ok = |(grant_oh_q & ~fifo_empty & ~fifo_wr_en);

  always_comb begin
    state_d     = state_q;
    grant_oh_d  = grant_oh_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    tx_data_d   = tx_data_q;
    tx_last_d   = tx_last_q;
    tx_chan_d   = tx_chan_q;
    fifo_rd_en  = '0;
    frame_abort = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_oh_d = pick_gnt;
          grant_d    = pick_idx;
          state_d    = StRead;
        end
      end
      StRead: begin
        if (read_ok) begin
          fifo_rd_en = grant_oh_q;
          timer_d    = '0;
          state_d    = StCapt;
        end else if (timer_q == TimerLast) begin
          frame_abort = 1'b1;
          rr_ptr_d    = grant_q;
          timer_d     = '0;
          state_d     = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StCapt: begin
        tx_data_d = fifo_dout[32'(grant_q)*WIDTH +: WIDTH];
        tx_last_d = fifo_dout_last[grant_q];
        tx_chan_d = grant_q;
        state_d   = StSend;
      end
      StSend: begin
        if (tx_ready) begin
          if (tx_last_q) begin
            rr_ptr_d = grant_q;
            state_d  = StIdle;
          end else begin
            state_d = StRead;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_oh_q <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= CH_W'(NUM_CH - 1);
      timer_q    <= '0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
      tx_chan_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_oh_q <= grant_oh_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
      tx_chan_q  <= tx_chan_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_last  = tx_last_q;
  assign tx_chan  = tx_chan_q;
  assign tx_valid = (state_q == StSend);
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_fifo_arbiter.sv
// Bench for uart_tx_fifo_arbiter: directed scenarios plus randomized frame
// sets checked against a frame-level round-robin reference.
module tb_uart_tx_fifo_arbiter;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fifo_empty;
  logic [3:0]  fifo_wr_en;
  logic [31:0] fifo_dout;
  logic [3:0]  fifo_dout_last;
  logic [3:0]  fifo_rd_en;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic [1:0]  tx_chan;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_abort;

  // FIFO model state; pre_* loads words without a visible write strobe.
  logic [8:0]  fq [4][$];
  logic [8:0]  wr_word [4];
  logic [3:0]  pre_en;
  logic [8:0]  pre_word [4];
  logic        fifo_clr;
  logic [7:0]  dout_r [4];
  logic [3:0]  last_r;

  int          n_checks = 0;
  int          n_errors = 0;
  int          viol = 0;
  int          aborts = 0;
  logic [10:0] rx [$];
  logic [10:0] exp_q [$];
  logic [8:0]  chq [4][$];
  logic [8:0]  ldq [4][$];

  always #5 clk = ~clk;

  uart_tx_fifo_arbiter #(
    .NUM_CH  (NUM_CH),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_dout      (fifo_dout),
    .fifo_dout_last (fifo_dout_last),
    .fifo_rd_en     (fifo_rd_en),
    .tx_data        (tx_data),
    .tx_last        (tx_last),
    .tx_chan        (tx_chan),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .busy           (busy),
    .frame_abort    (frame_abort)
  );

  always_comb begin
    fifo_dout = '0;
    for (int c = 0; c < 4; c++) fifo_dout[c*8 +: 8] = dout_r[c];
  end
  assign fifo_dout_last = last_r;

  always @(posedge clk) begin
    if (fifo_clr) begin
      for (int c = 0; c < 4; c++) begin
        fq[c].delete();
        dout_r[c] <= '0;
      end
      last_r     <= '0;
      fifo_empty <= '1;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (fifo_rd_en[c] && !fifo_wr_en[c] && fq[c].size() != 0) begin
          dout_r[c] <= fq[c][0][7:0];
          last_r[c] <= fq[c][0][8];
          fq[c].delete(0);
        end
        if (fifo_wr_en[c]) fq[c].push_back(wr_word[c]);
        if (pre_en[c]) fq[c].push_back(pre_word[c]);
        fifo_empty[c] <= (fq[c].size() == 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) rx.push_back({tx_chan, tx_last, tx_data});
      if (frame_abort) aborts <= aborts + 1;
      if ((fifo_rd_en & (fifo_empty | fifo_wr_en)) != 4'b0 || !$onehot0(fifo_rd_en))
        viol <= viol + 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int c, input logic [8:0] w);
    pre_en[c]   = 1'b1;
    pre_word[c] = w;
  endtask

  task automatic commit();
    cyc();
    pre_en = '0;
  endtask

  task automatic expect_byte(input string tag, input int ch, input logic [7:0] d, input logic l,
                             input int max_wait);
    int w;
    w = 0;
    while (!(tx_valid && tx_ready) && w < max_wait) begin
      cyc();
      w++;
    end
    chk({tag, "_seen"}, 32'(tx_valid & tx_ready), 32'd1);
    chk({tag, "_byte"}, 32'({tx_chan, tx_last, tx_data}), 32'({ch[1:0], l, d}));
    cyc();
  endtask

  function automatic logic [31:0] outs();
    return 32'({fifo_rd_en, busy, tx_valid, tx_last, frame_abort, tx_chan, tx_data});
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          nfr;
    int          len;
    int          total;
    int          left;
    int          ptr;
    int          ch;
    int          rx_base;
    int          waited;
    bit          found;
    bit          more;
    logic [8:0]  word;

    rst = 1'b1; fifo_clr = 1'b1; tx_ready = 1'b0; fifo_wr_en = '0; pre_en = '0;
    for (int c = 0; c < 4; c++) begin
      wr_word[c]  = '0;
      pre_word[c] = '0;
    end
    repeat (3) cyc();
    chk("reset_outputs", outs(), 32'd0);
    rst = 1'b0; fifo_clr = 1'b0;

    // All FIFOs empty: nothing happens for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      chk("idle_outputs", outs(), 32'd0);
      cyc();
    end

    // Single two-byte frame on ch1; first tx_valid three cycles after non-empty.
    tx_ready = 1'b1;
    load(1, {1'b0, 8'h41}); commit();
    chk("t2_empty_low", 32'(fifo_empty[1]), 32'd0);
    chk("t2_valid_c0", 32'(tx_valid), 32'd0);
    load(1, {1'b1, 8'h42}); commit();
    chk("t2_rd_en", 32'(fifo_rd_en), 32'h2);
    cyc();
    chk("t2_valid_c2", 32'(tx_valid), 32'd0);
    cyc();
    chk("t2_valid_c3", 32'(tx_valid), 32'd1);
    expect_byte("t2_b0", 1, 8'h41, 1'b0, 0);
    expect_byte("t2_b1", 1, 8'h42, 1'b1, 8);
    chk("t2_idle_after", 32'({busy, tx_valid}), 32'd0);

    // Fresh pointer: ch0 beats ch2, then ch3 beats ch0 once ch2 was last served.
    rst = 1'b1; cyc(); rst = 1'b0;
    load(0, {1'b0, 8'h10}); load(2, {1'b0, 8'h20}); commit();
    load(0, {1'b1, 8'h11}); load(2, {1'b1, 8'h21}); commit();
    expect_byte("t3_a0", 0, 8'h10, 1'b0, 10);
    expect_byte("t3_a1", 0, 8'h11, 1'b1, 10);
    expect_byte("t3_b0", 2, 8'h20, 1'b0, 10);
    expect_byte("t3_b1", 2, 8'h21, 1'b1, 10);
    load(0, {1'b0, 8'h30}); load(3, {1'b0, 8'h40}); commit();
    load(0, {1'b1, 8'h31}); load(3, {1'b1, 8'h41}); commit();
    expect_byte("t3_c0", 3, 8'h40, 1'b0, 10);
    expect_byte("t3_c1", 3, 8'h41, 1'b1, 10);
    expect_byte("t3_d0", 0, 8'h30, 1'b0, 10);
    expect_byte("t3_d1", 0, 8'h31, 1'b1, 10);

    // ch0 paused mid-frame: ch1 must wait for the refill and frame end.
    load(0, {1'b0, 8'h50}); commit();
    load(1, {1'b0, 8'h60}); commit();
    load(1, {1'b1, 8'h61}); commit();
    expect_byte("t4_b0", 0, 8'h50, 1'b0, 6);
    for (int i = 0; i < 10; i++) begin
      chk("t4_no_ch1_rd", 32'(fifo_rd_en[1]), 32'd0);
      chk("t4_busy", 32'({busy, tx_valid}), 32'h2);
      cyc();
    end
    load(0, {1'b1, 8'h51}); commit();
    expect_byte("t4_b1", 0, 8'h51, 1'b1, 6);
    expect_byte("t4_c0", 1, 8'h60, 1'b0, 10);
    expect_byte("t4_c1", 1, 8'h61, 1'b1, 10);

    // ch0 stalls for TIMEOUT cycles in READ, then ch1 takes over.
    load(0, {1'b0, 8'h70}); load(1, {1'b0, 8'h80}); commit();
    load(1, {1'b1, 8'h81}); commit();
    expect_byte("t5_b0", 0, 8'h70, 1'b0, 6);
    for (int i = 1; i <= 16; i++) begin
      if (i < 16) chk("t5_no_abort", 32'(frame_abort), 32'd0);
      else chk("t5_abort", 32'(frame_abort), 32'd1);
      chk("t5_no_rd", 32'(fifo_rd_en), 32'd0);
      cyc();
    end
    chk("t5_after_abort", 32'({frame_abort, busy, tx_valid}), 32'd0);
    expect_byte("t5_c0", 1, 8'h80, 1'b0, 6);
    expect_byte("t5_c1", 1, 8'h81, 1'b1, 6);
    chk("t5_abort_count", 32'(aborts), 32'd1);

    // Write collides with the read: read slips one cycle; then a stalled TX.
    load(2, {1'b0, 8'h90}); commit();
    load(2, {1'b1, 8'h91}); commit();
    fifo_wr_en[2] = 1'b1; wr_word[2] = {1'b1, 8'h93};
    #1;
    chk("t6_rd_blocked", 32'(fifo_rd_en), 32'd0);
    chk("t6_busy", 32'(busy), 32'd1);
    cyc();
    fifo_wr_en[2] = 1'b0;
    #1;
    chk("t6_rd_late", 32'(fifo_rd_en), 32'h4);
    cyc();
    tx_ready = 1'b0;
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk("t6_hold", 32'({tx_valid, tx_chan, tx_last, tx_data}), 32'({1'b1, 2'd2, 1'b0, 8'h90}));
      cyc();
    end
    tx_ready = 1'b1;
    expect_byte("t6_b0", 2, 8'h90, 1'b0, 0);
    expect_byte("t6_b1", 2, 8'h91, 1'b1, 6);
    expect_byte("t6_c0", 2, 8'h93, 1'b1, 10);

    // Reset asserted while a byte waits in SEND.
    tx_ready = 1'b0;
    load(3, {1'b0, 8'hA0}); commit();
    load(3, {1'b1, 8'hA1}); commit();
    w = 0;
    while (!tx_valid && w < 10) begin
      cyc();
      w++;
    end
    chk("t7_in_send", 32'({tx_valid, tx_data}), 32'h1A0);
    rst = 1'b1; fifo_clr = 1'b1;
    #1;
    chk("t7_async_clear", outs(), 32'd0);
    cyc();
    chk("t7_edge_clear", outs(), 32'd0);
    rst = 1'b0; fifo_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t7_idle", outs(), 32'd0);
      cyc();
    end

    // Randomized frame sets, all channels loaded while held in reset.
    for (int r = 0; r < 3; r++) begin
      rst = 1'b1; fifo_clr = 1'b1; tx_ready = 1'b0;
      cyc();
      fifo_clr = 1'b0;
      exp_q.delete();
      total = 0;
      for (int c = 0; c < 4; c++) begin
        chq[c].delete();
        ldq[c].delete();
        nfr = $urandom_range(1, 3);
        total += nfr;
        for (int f = 0; f < nfr; f++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            word = {b == len - 1, 8'($urandom)};
            chq[c].push_back(word);
            ldq[c].push_back(word);
          end
        end
      end
      // Reference: whole frames served in round-robin order from pointer 3.
      ptr  = 3;
      left = total;
      while (left > 0) begin
        found = 1'b0;
        for (int off = 1; off <= 4; off++) begin
          ch = (ptr + off) % 4;
          if (!found && chq[ch].size() > 0) begin
            found = 1'b1;
            ptr   = ch;
            left--;
            do begin
              word = chq[ch].pop_front();
              exp_q.push_back({2'(ch), word});
            end while (!word[8]);
          end
        end
      end
      more = 1'b1;
      while (more) begin
        more = 1'b0;
        for (int c = 0; c < 4; c++) begin
          if (ldq[c].size() > 0) begin
            load(c, ldq[c].pop_front());
            more = 1'b1;
          end
        end
        if (more) commit();
      end
      cyc();
      rst = 1'b0;
      rx_base = rx.size();
      waited  = 0;
      while ((rx.size() - rx_base) < exp_q.size() && waited < 3000) begin
        tx_ready = ($urandom_range(0, 3) != 0);
        cyc();
        waited++;
      end
      tx_ready = 1'b0;
      cyc();
      chk("rand_count", 32'(rx.size() - rx_base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
        chk("rand_byte", 32'(rx[rx_base + i]), 32'(exp_q[i]));
      end
    end

    chk("rd_en_rule", 32'(viol), 32'd0);
    chk("abort_total", 32'(aborts), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
